// File: rtl/fsm_pkg.sv
// Shared definitions for the ring-FSM trace decoder: default ring size,
// controller states and error codes.
package fsm_pkg;

   localparam int FSM_NUM_STATES = 9;
   localparam int FSM_SW         = $clog2(FSM_NUM_STATES);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRACK = 2'd1,
      ST_ERROR = 2'd2
   } ctrl_state_e;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_RANGE = 2'b01;
   localparam logic [1:0] ERR_JUMP  = 2'b10;

endpackage

// File: rtl/fsm_decode_step.sv
// Combinational classifier: relates the new sample a to the previous legal
// state and reports which ring transition (if any) it represents.
module fsm_decode_step #(
   parameter int NUM_STATES = 9,
   parameter int SW         = $clog2(NUM_STATES)
) (
   input  logic [SW-1:0] prev,
   input  logic [SW-1:0] a,
   output logic          hold,
   output logic          advance,
   output logic          wrap,
   output logic          range_err,
   output logic          jump_err,
   output logic [SW-1:0] ev_idx
);

   localparam logic [SW-1:0] LAST = SW'(NUM_STATES - 1);

   // One extra bit so a ring that fills the whole word still compares correctly
   assign range_err = ({1'b0, a} >= (SW+1)'(NUM_STATES));
   assign hold      = !range_err && (a == prev);
   assign advance   = !range_err && (prev < LAST) && (a == prev + SW'(1));
   assign wrap      = !range_err && (prev == LAST) && (a == '0);
   assign jump_err  = !range_err && !hold && !advance && !wrap;
   assign ev_idx    = prev;

endmodule

// File: rtl/fsm_decode.sv
// Trace decoder for the ring FSM: turns sampled state words into one-hot
// advance events, counts laps and latches the first illegal observation.
module fsm_decode
   import fsm_pkg::*;
#(
   parameter int NUM_STATES = FSM_NUM_STATES,
   parameter int SW         = $clog2(NUM_STATES),
   parameter int LAP_W      = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  valid,
   input  logic                  clear,
   input  logic [SW-1:0]         a,
   output logic [NUM_STATES-1:0] ev,
   output logic [LAP_W-1:0]      lap,
   output logic                  lap_wrap,
   output logic                  err,
   output logic [1:0]            err_code,
   output logic [SW-1:0]         err_state
);

   ctrl_state_e           state_q;
   logic [SW-1:0]         prev_q;
   logic [NUM_STATES-1:0] ev_q;
   logic [LAP_W-1:0]      lap_q;
   logic [LAP_W-1:0]      lap_d;
   logic                  lap_wrap_q;
   logic                  err_q;
   logic [1:0]            err_code_q;
   logic [SW-1:0]         err_state_q;

   logic                  hold;
   logic                  advance;
   logic                  wrap;
   logic                  range_err;
   logic                  jump_err;
   logic [SW-1:0]         ev_idx;
   logic [NUM_STATES-1:0] ev_hot;

   fsm_decode_step #(
      .NUM_STATES (NUM_STATES),
      .SW         (SW)
   ) u_step (
      .prev      (prev_q),
      .a         (a),
      .hold      (hold),
      .advance   (advance),
      .wrap      (wrap),
      .range_err (range_err),
      .jump_err  (jump_err),
      .ev_idx    (ev_idx)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NUM_STATES; gi++) begin : g_ev_hot
         assign ev_hot[gi] = (ev_idx == SW'(gi));
      end
   endgenerate

   assign lap_d = lap_q + LAP_W'(1);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         prev_q      <= '0;
         ev_q        <= '0;
         lap_q       <= '0;
         lap_wrap_q  <= 1'b0;
         err_q       <= 1'b0;
         err_code_q  <= ERR_NONE;
         err_state_q <= '0;
      end else begin
         ev_q       <= '0;
         lap_wrap_q <= 1'b0;
         // clear wins over a coincident sample, which is simply dropped
         if (clear) begin
            state_q     <= ST_IDLE;
            prev_q      <= '0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_state_q <= '0;
         end else if (valid) begin
            case (state_q)
               ST_IDLE: begin
                  if (range_err) begin
                     state_q     <= ST_ERROR;
                     err_q       <= 1'b1;
                     err_code_q  <= ERR_RANGE;
                     err_state_q <= a;
                  end else begin
                     state_q <= ST_TRACK;
                     prev_q  <= a;
                  end
               end
               ST_TRACK: begin
                  if (range_err || jump_err) begin
                     state_q     <= ST_ERROR;
                     err_q       <= 1'b1;
                     err_code_q  <= range_err ? ERR_RANGE : ERR_JUMP;
                     err_state_q <= a;
                  end else if (!hold && (advance || wrap)) begin
                     ev_q   <= ev_hot;
                     prev_q <= a;
                     if (wrap) begin
                        lap_q      <= lap_d;
                        lap_wrap_q <= (lap_d == '0);
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign ev        = ev_q;
   assign lap       = lap_q;
   assign lap_wrap  = lap_wrap_q;
   assign err       = err_q;
   assign err_code  = err_code_q;
   assign err_state = err_state_q;

endmodule

// File: tb/tb_fsm_decode.sv
// Self-checking bench for fsm_decode: directed scenarios plus random traces
// compared against an arithmetic reference model of the ring decoder.
module tb_fsm_decode;

   localparam int N  = 9;
   localparam int SW = 4;
   localparam int LW = 2;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          valid = 1'b0;
   logic          clear = 1'b0;
   logic [SW-1:0] a     = '0;
   logic [N-1:0]  ev;
   logic [LW-1:0] lap;
   logic          lap_wrap;
   logic          err;
   logic [1:0]    err_code;
   logic [SW-1:0] err_state;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: mode 0 = no previous sample, 1 = tracking, 2 = stuck in error
   int m_mode = 0;
   int m_prev = 0;
   int m_lap  = 0;
   int m_err  = 0;
   int m_code = 0;
   int m_est  = 0;
   int m_ev   = 0;
   int m_wrap = 0;

   fsm_decode #(
      .NUM_STATES (N),
      .SW         (SW),
      .LAP_W      (LW)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .valid     (valid),
      .clear     (clear),
      .a         (a),
      .ev        (ev),
      .lap       (lap),
      .lap_wrap  (lap_wrap),
      .err       (err),
      .err_code  (err_code),
      .err_state (err_state)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
      end
   endtask

   task automatic check_outputs();
      check("ev",        int'(ev),        m_ev);
      check("lap",       int'(lap),       m_lap);
      check("lap_wrap",  int'(lap_wrap),  m_wrap);
      check("err",       int'(err),       m_err);
      check("err_code",  int'(err_code),  m_code);
      check("err_state", int'(err_state), m_est);
   endtask

   task automatic model_error(input int code, input int av);
      m_mode = 2;
      m_err  = 1;
      m_code = code;
      m_est  = av;
   endtask

   task automatic model_step(input bit v, input bit c, input int av);
      m_ev   = 0;
      m_wrap = 0;
      if (c) begin
         m_mode = 0;
         m_prev = 0;
         m_err  = 0;
         m_code = 0;
         m_est  = 0;
      end else if (v && m_mode != 2) begin
         if (av >= N) begin
            model_error(1, av);
         end else if (m_mode == 0) begin
            m_mode = 1;
            m_prev = av;
         end else if (av == m_prev) begin
            // holding in the same ring state
         end else if (av == (m_prev + 1) % N) begin
            m_ev = 1 << m_prev;
            if (m_prev == N - 1) begin
               m_lap = (m_lap + 1) % (1 << LW);
               m_wrap = (m_lap == 0) ? 1 : 0;
            end
            m_prev = av;
         end else begin
            model_error(2, av);
         end
      end
   endtask

   task automatic cycle(input bit v, input bit c, input int av);
      valid = v;
      clear = c;
      a     = SW'(av);
      @(posedge clock);
      model_step(v, c, av);
      #1;
      check_outputs();
      $display("txn valid=%0b clear=%0b a=%0d -> ev=0x%03h lap=%0d wrap=%0b err=%0b code=%0d est=%0d",
               v, c, av, ev, lap, lap_wrap, err, err_code, err_state);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      valid = 1'b0;
      clear = 1'b0;
      @(posedge clock);
      m_mode = 0; m_prev = 0; m_lap = 0; m_err = 0;
      m_code = 0; m_est = 0; m_ev = 0; m_wrap = 0;
      #1;
      check_outputs();
      $display("txn reset -> ev=0x%03h lap=%0d err=%0b", ev, lap, err);
      reset = 1'b0;
   endtask

   initial begin
      int sel;
      int av;
      bit v;
      bit c;

      // Full lap 0..8,0
      do_reset();
      for (int k = 0; k < N; k++) cycle(1'b1, 1'b0, k);
      cycle(1'b1, 1'b0, 0);

      // Holds with gaps, then an advance
      do_reset();
      cycle(1'b1, 1'b0, 3);
      cycle(1'b0, 1'b0, 0);
      cycle(1'b1, 1'b0, 3);
      cycle(1'b0, 1'b0, 7);
      cycle(1'b1, 1'b0, 3);
      cycle(1'b1, 1'b0, 4);

      // Illegal jump, ignored samples, clear, fresh start
      do_reset();
      cycle(1'b1, 1'b0, 2);
      cycle(1'b1, 1'b0, 5);
      cycle(1'b1, 1'b0, 6);
      cycle(1'b1, 1'b0, 7);
      cycle(1'b0, 1'b1, 0);
      cycle(1'b1, 1'b0, 6);
      cycle(1'b1, 1'b0, 7);

      // Out of range first sample; later bad value keeps first code
      do_reset();
      cycle(1'b1, 1'b0, 12);
      cycle(1'b1, 1'b0, 10);
      cycle(1'b0, 1'b1, 0);
      cycle(1'b1, 1'b0, 4);
      cycle(1'b1, 1'b0, 15);

      // Four full laps to wrap the 2-bit lap counter
      do_reset();
      cycle(1'b1, 1'b0, 0);
      for (int l = 0; l < 4; l++) begin
         for (int k = 1; k < N; k++) cycle(1'b1, 1'b0, k);
         cycle(1'b1, 1'b0, 0);
      end
      cycle(1'b1, 1'b0, 1);

      // clear beats valid; reset mid-lap
      do_reset();
      cycle(1'b1, 1'b0, 0);
      cycle(1'b1, 1'b1, 1);
      cycle(1'b1, 1'b0, 2);
      do_reset();
      for (int k = 0; k <= 5; k++) cycle(1'b1, 1'b0, k);
      do_reset();
      cycle(1'b1, 1'b0, 6);
      cycle(1'b1, 1'b0, 7);

      // Random traces biased towards legal ring progress
      do_reset();
      for (int i = 0; i < 800; i++) begin
         sel = $urandom_range(0, 99);
         if (sel < 2) begin
            do_reset();
         end else begin
            c = (sel < 6);
            v = ($urandom_range(0, 9) < 8);
            sel = $urandom_range(0, 9);
            if (sel < 5)      av = (m_prev + 1) % N;
            else if (sel < 7) av = m_prev;
            else              av = $urandom_range(0, 15);
            cycle(v, c, av);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fsm_decode.md
# fsm_decode

Trace decoder for the 9-state ring FSM: observes the sampled state word once per valid cycle and reconstructs which advance input (i0..i8) fired. It emits a registered one-hot event strobe, counts completed laps (8→0 wraps) and flags illegal or out-of-range state sequences. It sits on the observation side of the FSM, fed from the registered state, and drives monitors and coverage counters.

## Interface
- NUM_STATES, 9, ring length; legal states 0..NUM_STATES-1
- SW, $clog2(NUM_STATES) (4), state word width
- LAP_W, 8, lap counter width
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- valid  in  1  a carries a state sample this cycle
- clear  in  1  drop history and error, return to IDLE
- a  in  SW  sampled FSM state
- ev  out  NUM_STATES  one-hot event strobe, one cycle; ev[k] = input ik fired
- lap  out  LAP_W  completed-lap count
- lap_wrap  out  1  one-cycle pulse when lap wraps to 0
- err  out  1  sticky error flag
- err_code  out  2  01 out-of-range state, 10 illegal transition; first error only
- err_state  out  SW  value of a that raised the first error

## Operation
- Controller states: IDLE (no previous sample), TRACK (prev holds last legal state), ERROR (sticky).
- IDLE: on valid with a < NUM_STATES → prev := a, go TRACK, no event. On valid with a ≥ NUM_STATES → error 01.
- TRACK, on valid:
  - a == prev → hold, no event.
  - a == prev+1 and prev < NUM_STATES-1 → ev[prev]=1, prev := a.
  - prev == NUM_STATES-1 and a == 0 → ev[NUM_STATES-1]=1, lap := lap+1 (mod 2^LAP_W), lap_wrap=1 when lap goes from all-ones to 0, prev := 0.
  - a ≥ NUM_STATES → error 01.
  - any other value → error 10.
- Error entry: err := 1, err_code and err_state latched, go ERROR, no event that cycle.
- ERROR: ignore valid; ev stays 0; lap frozen; err fields held. Leave only via clear or reset.
- clear (any state): go IDLE, err := 0, err_code := 00, err_state := 0, ev := 0. lap is NOT cleared. clear beats valid in the same cycle; that sample is discarded.
- valid low: no state change, ev = 0, lap_wrap = 0.

## Timing
- All outputs registered. Sample on valid at edge N → ev/lap/lap_wrap/err visible after edge N+1 (latency 1).
- ev and lap_wrap are single-cycle pulses; at most one ev bit high.
- Back-to-back valid every cycle supported; throughput 1 sample/cycle.
- Reset values: ev=0, lap=0, lap_wrap=0, err=0, err_code=00, err_state=0; controller IDLE, prev=0.
- Reset mid-trace: next valid sample is treated as first (no event even if a == prev+1).
- Lap counter wraps silently except the lap_wrap pulse; no saturation.

## Structure
- Shared package fsm_pkg: NUM_STATES default, SW, controller state enum (IDLE/TRACK/ERROR), err_code constants (ERR_NONE=00, ERR_RANGE=01, ERR_JUMP=10).
- One sub-module: fsm_decode_step — combinational classifier (prev, a) → {hold, advance, wrap, range_err, jump_err} plus event index; the top holds prev, controller, lap counter and output registers.

## Test plan
- Full lap: reset, valid samples 0,1,2,…,8,0 → ev pulses 0x001,0x002,…,0x100 one cycle after each advance; lap=1 after final sample; err=0.
- Holds and gaps: samples 3,3,3 with valid low between → no ev; then 4 → ev=0x008 only.
- Illegal jump: samples 2,5 → err=1, err_code=10, err_state=5, ev=0; further samples 6,7 ignored; clear → err=0, next sample 6 gives no event (IDLE).
- Out of range: first sample 12 → err=1, err_code=01, err_state=12; later 10 leaves err_code=01.
- Lap wrap (LAP_W=2): four full laps → lap 1,2,3,0 with lap_wrap high exactly one cycle at the 4th 8→0.
- Simultaneous/reset: clear and valid(a=1) same cycle after prev=0 → no ev, state IDLE; reset asserted mid-lap at prev=5 then samples 6,7 → first gives no ev, second ev=0x040; lap=0.
